// File: rtl/rob_recovery_ctrl.sv
// rob_recovery_ctrl
//   Retire-side controller for the reorder buffer. Grants in-order retirement
//   to the two ROB head slots, detects a mispredicted branch at retirement and
//   sequences recovery: pipeline flush, store-buffer drain, fetch redirect.
//   Dispatch is held stalled from the cycle after capture until the redirect
//   cycle has completed.
//
// Ports
//   CLK, RST_N                 clock (rising edge), async active-low reset
//   Commit{1,2}_V              head / head+1 slot holds an executed entry
//   Commit{1,2}_Mispred        that entry is a mispredicted branch
//   Commit{1,2}_New_PC         correct target for the slot
//   Commit{1,2}_Index          ROB index of the slot
//   SB_Empty                   store buffer holds no committed-unwritten stores
//   Retire1_En, Retire2_En     retire slot 1 / slot 2 this cycle
//   Flush                      clear ROB, RS and speculative rename state
//   Dispatch_Stall             block decoder dispatch
//   Redirect_V, Redirect_PC    one-cycle fetch redirect strobe and target
//   Mispred_Index              ROB index of the last recovered branch
//   Mispred_Count              saturating count of recoveries
//   Drain_Error                sticky: store-buffer drain timed out

module rob_recovery_ctrl #(
  parameter int unsigned ROB_INDEX_SIZE = 7,
  parameter int unsigned FLUSH_CYCLES   = 2,   // legal 1..15
  parameter int unsigned DRAIN_TIMEOUT  = 64,  // legal 1..255
  parameter int unsigned CNT_W          = 16
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic                      Commit1_V,
  input  logic                      Commit1_Mispred,
  input  logic [15:0]               Commit1_New_PC,
  input  logic [ROB_INDEX_SIZE-1:0] Commit1_Index,
  input  logic                      Commit2_V,
  input  logic                      Commit2_Mispred,
  input  logic [15:0]               Commit2_New_PC,
  input  logic [ROB_INDEX_SIZE-1:0] Commit2_Index,
  input  logic                      SB_Empty,
  output logic                      Retire1_En,
  output logic                      Retire2_En,
  output logic                      Flush,
  output logic                      Dispatch_Stall,
  output logic                      Redirect_V,
  output logic [15:0]               Redirect_PC,
  output logic [ROB_INDEX_SIZE-1:0] Mispred_Index,
  output logic [CNT_W-1:0]          Mispred_Count,
  output logic                      Drain_Error
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_DRAIN    = 2'd2,
    ST_REDIRECT = 2'd3
  } state_e;

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);
  localparam logic [7:0] DRAIN_LAST = 8'(DRAIN_TIMEOUT - 1);

  state_e                      state_q, state_d;
  logic [3:0]                  flush_cnt_q, flush_cnt_d;
  logic [7:0]                  drain_cnt_q, drain_cnt_d;
  logic [15:0]                 pc_q, pc_d;
  logic [ROB_INDEX_SIZE-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]            mcnt_q, mcnt_d;
  logic                        derr_q, derr_d;

  logic run;
  logic retire1, retire2;
  logic cap1, cap2;

  // Retirement: slot 2 only follows a valid, non-mispredicting slot 1, so a
  // mispredicting instruction retires but nothing younger passes it.
  always_comb begin
    run     = (state_q == ST_RUN);
    retire1 = run & Commit1_V;
    retire2 = run & Commit1_V & ~Commit1_Mispred & Commit2_V;
    cap1    = retire1 & Commit1_Mispred;
    cap2    = retire2 & Commit2_Mispred;
  end

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    drain_cnt_d = drain_cnt_q;
    pc_d        = pc_q;
    idx_d       = idx_q;
    mcnt_d      = mcnt_q;
    derr_d      = derr_q;

    unique case (state_q)
      ST_RUN: begin
        if (cap1 || cap2) begin
          // Slot 1 is older, so its mispredict wins; cap2 implies !cap1.
          if (cap1) begin
            pc_d  = Commit1_New_PC;
            idx_d = Commit1_Index;
          end else begin
            pc_d  = Commit2_New_PC;
            idx_d = Commit2_Index;
          end
          state_d     = ST_FLUSH;
          flush_cnt_d = FLUSH_LOAD;
          if (mcnt_q != '1) begin
            mcnt_d = mcnt_q + 1'b1;
          end
        end
      end

      ST_FLUSH: begin
        if (flush_cnt_q == '0) begin
          state_d     = ST_DRAIN;
          drain_cnt_d = '0;
        end else begin
          flush_cnt_d = flush_cnt_q - 4'd1;
        end
      end

      ST_DRAIN: begin
        // SB_Empty is honoured on the first DRAIN cycle; the timeout only
        // fires on a cycle where the buffer is still not empty.
        if (SB_Empty) begin
          state_d = ST_REDIRECT;
        end else if (drain_cnt_q == DRAIN_LAST) begin
          derr_d  = 1'b1;
          state_d = ST_REDIRECT;
        end else begin
          drain_cnt_d = drain_cnt_q + 8'd1;
        end
      end

      ST_REDIRECT: begin
        state_d = ST_RUN;
      end

      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= ST_RUN;
      flush_cnt_q <= '0;
      drain_cnt_q <= '0;
      pc_q        <= '0;
      idx_q       <= '0;
      mcnt_q      <= '0;
      derr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      pc_q        <= pc_d;
      idx_q       <= idx_d;
      mcnt_q      <= mcnt_d;
      derr_q      <= derr_d;
    end
  end

  always_comb begin
    Retire1_En     = retire1;
    Retire2_En     = retire2;
    Flush          = (state_q == ST_FLUSH);
    Dispatch_Stall = (state_q != ST_RUN);
    Redirect_V     = (state_q == ST_REDIRECT);
    Redirect_PC    = pc_q;
    Mispred_Index  = idx_q;
    Mispred_Count  = mcnt_q;
    Drain_Error    = derr_q;
  end

endmodule
